// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: byte memory port, decoder lookup, redirect and
// the instruction handshake toward execute.
interface inst_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [7:0]  dec_opcode;
    logic [1:0]  dec_len;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_opcode;
    logic [7:0]  inst_op1;
    logic [7:0]  inst_op2;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;
    logic [15:0] inst_next_pc;

    // The fetch stage drives addresses, decoder opcode and the instruction.
    modport master (
        output mem_addr, mem_rd, dec_opcode,
        output inst_valid, inst_opcode, inst_op1, inst_op2,
        output inst_len, inst_pc, inst_next_pc,
        input  mem_rdata, dec_len, redirect, redirect_pc, inst_ready
    );

    // Memory, decoder and execute side seen from outside the fetch stage.
    modport slave (
        input  mem_addr, mem_rd, dec_opcode,
        input  inst_valid, inst_opcode, inst_op1, inst_op2,
        input  inst_len, inst_pc, inst_next_pc,
        output mem_rdata, dec_len, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// 6502 instruction fetch: reads the opcode, asks the decoder for the length,
// reads 0..2 operand bytes and offers the instruction with valid/ready.
// A redirect abandons whatever is in flight and restarts at a new PC.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);
    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_OPW   = 3'd1,
        S_OPR   = 3'd2,
        S_B1W   = 3'd3,
        S_B2W   = 3'd4,
        S_VALID = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] inst_pc_r, inst_pc_s;
    logic [7:0]  opcode_r, opcode_s;
    logic [7:0]  op1_r, op1_s;
    logic [7:0]  op2_r, op2_s;
    logic [1:0]  len_r, len_s;
    logic        rd_s;
    logic [1:0]  dec_len_s;

    // A decoder length of zero is meaningless; treat it as a 1-byte opcode.
    assign dec_len_s = (bus.dec_len == 2'd0) ? 2'd1 : bus.dec_len;

    // Next-state and datapath updates; redirect overrides everything.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        inst_pc_s = inst_pc_r;
        opcode_s  = opcode_r;
        op1_s     = op1_r;
        op2_s     = op2_r;
        len_s     = len_r;
        rd_s      = 1'b0;
        if (bus.redirect) begin
            // Abandon the fetch; any returning data is never latched in S_OP.
            pc_s    = bus.redirect_pc;
            state_s = S_OP;
        end else begin
            case (state_r)
                S_OP: begin
                    rd_s      = 1'b1;
                    inst_pc_s = pc_r;
                    pc_s      = pc_r + 16'd1;
                    state_s   = S_OPW;
                end
                S_OPW: begin
                    opcode_s = bus.mem_rdata;
                    op1_s    = 8'h00;
                    op2_s    = 8'h00;
                    state_s  = S_OPR;
                end
                S_OPR: begin
                    len_s = dec_len_s;
                    if (dec_len_s != 2'd1) begin
                        rd_s    = 1'b1;
                        pc_s    = pc_r + 16'd1;
                        state_s = S_B1W;
                    end else begin
                        state_s = S_VALID;
                    end
                end
                S_B1W: begin
                    op1_s = bus.mem_rdata;
                    if (len_r == 2'd3) begin
                        rd_s    = 1'b1;
                        pc_s    = pc_r + 16'd1;
                        state_s = S_B2W;
                    end else begin
                        state_s = S_VALID;
                    end
                end
                S_B2W: begin
                    op2_s   = bus.mem_rdata;
                    state_s = S_VALID;
                end
                S_VALID: begin
                    // Accepting cycle doubles as the next opcode read.
                    if (bus.inst_ready) begin
                        rd_s      = 1'b1;
                        inst_pc_s = pc_r;
                        pc_s      = pc_r + 16'd1;
                        state_s   = S_OPW;
                    end else begin
                        state_s = S_VALID;
                    end
                end
                default: begin
                    state_s = S_OP;
                end
            endcase
        end
    end

    // State and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_OP;
            pc_r      <= RESET_PC;
            inst_pc_r <= 16'h0000;
            opcode_r  <= 8'h00;
            op1_r     <= 8'h00;
            op2_r     <= 8'h00;
            len_r     <= 2'd1;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            inst_pc_r <= inst_pc_s;
            opcode_r  <= opcode_s;
            op1_r     <= op1_s;
            op2_r     <= op2_s;
            len_r     <= len_s;
        end
    end

    assign bus.mem_addr     = pc_r;
    assign bus.mem_rd       = rd_s & ~rst;
    assign bus.dec_opcode   = opcode_r;
    assign bus.inst_valid   = (state_r == S_VALID);
    assign bus.inst_opcode  = opcode_r;
    assign bus.inst_op1     = op1_r;
    assign bus.inst_op2     = op2_r;
    assign bus.inst_len     = len_r;
    assign bus.inst_pc      = inst_pc_r;
    assign bus.inst_next_pc = inst_pc_r + {14'd0, len_r};
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: behavioural byte memory with one-cycle read
// latency and a table-driven decoder length lookup.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst;
    int   vec  = 0;
    int   errs = 0;
    logic [7:0] mem [0:65535];
    logic       ovr_en;
    logic [1:0] ovr_len;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(16'h0200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] dec_model(input logic [7:0] op);
        case (op)
            8'hEA:   return 2'd1;
            8'hAD:   return 2'd3;
            8'hA9:   return 2'd2;
            8'h02:   return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    assign bus.dec_len = ovr_en ? ovr_len : dec_model(bus.dec_opcode);

    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    // Leaves the bench at cycle 0 (first cycle with rst low), 1 ns past negedge.
    task automatic do_reset();
        rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
        bus.inst_ready = 1'b0; ovr_en = 1'b0; ovr_len = 2'd0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic next(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
        bus.inst_ready = 1'b0; ovr_en = 1'b0; ovr_len = 2'd0;
        @(negedge clk); @(negedge clk); #1;
        vec++; if ({bus.mem_rd, bus.inst_valid} !== 2'b00) begin errs++;
            $display("FAIL reset_rd_valid: got %b want 00", {bus.mem_rd, bus.inst_valid}); end
        vec++; if ({bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc}
                   !== {8'h00, 8'h00, 8'h00, 2'd1, 16'h0000}) begin errs++;
            $display("FAIL reset_regs: got %h want %h",
                {bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc},
                {8'h00, 8'h00, 8'h00, 2'd1, 16'h0000}); end
        rst = 1'b0; #1;
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0200}) begin errs++;
            $display("FAIL reset_first_read: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0200}); end
    endtask

    task automatic test_single();
        clear_mem(); mem[16'h0200] = 8'hEA;
        do_reset();
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0200}) begin errs++;
            $display("FAIL single_c0_read: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0200}); end
        for (int k = 1; k <= 2; k++) begin
            next(1);
            vec++; if (bus.inst_valid !== 1'b0) begin errs++;
                $display("FAIL single_early_valid c%0d: got %b want 0", k, bus.inst_valid); end
        end
        next(1);
        vec++; if (bus.inst_valid !== 1'b1) begin errs++;
            $display("FAIL single_valid_c3: got %b want 1", bus.inst_valid); end
        vec++; if ({bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc, bus.inst_next_pc}
                   !== {8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200, 16'h0201}) begin errs++;
            $display("FAIL single_fields: got %h want %h",
                {bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc, bus.inst_next_pc},
                {8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200, 16'h0201}); end
        vec++; if (bus.dec_opcode !== 8'hEA) begin errs++;
            $display("FAIL single_dec_opcode: got %h want ea", bus.dec_opcode); end
        bus.inst_ready = 1'b1; #1;
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0201}) begin errs++;
            $display("FAIL single_accept_read: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0201}); end
        next(1); bus.inst_ready = 1'b0; #1;
        vec++; if (bus.inst_valid !== 1'b0) begin errs++;
            $display("FAIL single_after_accept: got %b want 0", bus.inst_valid); end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12; mem[16'h0203] = 8'hEA;
        do_reset();
        bus.inst_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            next(1);
            vec++; if (bus.inst_valid !== 1'b0) begin errs++;
                $display("FAIL b2b_early_valid c%0d: got %b want 0", k, bus.inst_valid); end
        end
        next(1);
        vec++; if ({bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc, bus.inst_next_pc}
                   !== {1'b1, 8'hAD, 8'h34, 8'h12, 2'd3, 16'h0200, 16'h0203}) begin errs++;
            $display("FAIL b2b_first_inst: got %h want %h",
                {bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc, bus.inst_next_pc},
                {1'b1, 8'hAD, 8'h34, 8'h12, 2'd3, 16'h0200, 16'h0203}); end
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0203}) begin errs++;
            $display("FAIL b2b_next_read: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0203}); end
        for (int k = 6; k <= 7; k++) begin
            next(1);
            vec++; if (bus.inst_valid !== 1'b0) begin errs++;
                $display("FAIL b2b_gap_valid c%0d: got %b want 0", k, bus.inst_valid); end
        end
        next(1);
        vec++; if ({bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc, bus.inst_next_pc}
                   !== {1'b1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0203, 16'h0204}) begin errs++;
            $display("FAIL b2b_second_inst: got %h want %h",
                {bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_op2, bus.inst_len, bus.inst_pc, bus.inst_next_pc},
                {1'b1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0203, 16'h0204}); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        clear_mem();
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h55; mem[16'h0202] = 8'hEA;
        do_reset();
        next(4);
        ovr_en = 1'b1; ovr_len = 2'd3;   // decoder changes its mind after the latch
        for (int k = 4; k <= 7; k++) begin
            #1;
            vec++; if ({bus.inst_valid, bus.mem_rd, bus.mem_addr, bus.inst_opcode, bus.inst_op1, bus.inst_len, bus.inst_next_pc}
                       !== {1'b1, 1'b0, 16'h0202, 8'hA9, 8'h55, 2'd2, 16'h0202}) begin errs++;
                $display("FAIL bp_hold c%0d: got %h want %h", k,
                    {bus.inst_valid, bus.mem_rd, bus.mem_addr, bus.inst_opcode, bus.inst_op1, bus.inst_len, bus.inst_next_pc},
                    {1'b1, 1'b0, 16'h0202, 8'hA9, 8'h55, 2'd2, 16'h0202}); end
            next(1);
        end
        ovr_en = 1'b0; bus.inst_ready = 1'b1; #1;
        vec++; if ({bus.inst_valid, bus.mem_rd, bus.mem_addr} !== {1'b1, 1'b1, 16'h0202}) begin errs++;
            $display("FAIL bp_accept: got %h want %h", {bus.inst_valid, bus.mem_rd, bus.mem_addr}, {1'b1, 1'b1, 16'h0202}); end
        next(1); bus.inst_ready = 1'b0;
        next(2);
        vec++; if ({bus.inst_valid, bus.inst_opcode, bus.inst_pc} !== {1'b1, 8'hEA, 16'h0202}) begin errs++;
            $display("FAIL bp_follower: got %h want %h", {bus.inst_valid, bus.inst_opcode, bus.inst_pc}, {1'b1, 8'hEA, 16'h0202}); end
    endtask

    task automatic test_redirect_mid();
        clear_mem();
        mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12; mem[16'h0400] = 8'hEA;
        do_reset();
        next(3);                         // cycle 3: waiting for op1
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0400; #1;
        vec++; if (bus.mem_rd !== 1'b0) begin errs++;
            $display("FAIL redir_rd_forced: got %b want 0", bus.mem_rd); end
        next(1); bus.redirect = 1'b0; #1;
        vec++; if ({bus.inst_valid, bus.mem_rd, bus.mem_addr, bus.inst_op1} !== {1'b0, 1'b1, 16'h0400, 8'h00}) begin errs++;
            $display("FAIL redir_restart: got %h want %h",
                {bus.inst_valid, bus.mem_rd, bus.mem_addr, bus.inst_op1}, {1'b0, 1'b1, 16'h0400, 8'h00}); end
        next(3);
        vec++; if ({bus.inst_valid, bus.inst_opcode, bus.inst_len, bus.inst_pc, bus.inst_next_pc}
                   !== {1'b1, 8'hEA, 2'd1, 16'h0400, 16'h0401}) begin errs++;
            $display("FAIL redir_target_inst: got %h want %h",
                {bus.inst_valid, bus.inst_opcode, bus.inst_len, bus.inst_pc, bus.inst_next_pc},
                {1'b1, 8'hEA, 2'd1, 16'h0400, 16'h0401}); end
    endtask

    task automatic test_redirect_handshake();
        clear_mem();
        mem[16'h0200] = 8'hEA; mem[16'h0201] = 8'hA9; mem[16'h0300] = 8'h02;
        do_reset();
        next(3);
        bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 16'h0300; #1;
        vec++; if ({bus.inst_valid, bus.mem_rd} !== 2'b10) begin errs++;
            $display("FAIL rh_same_cycle: got %b want 10", {bus.inst_valid, bus.mem_rd}); end
        next(1); bus.inst_ready = 1'b0; bus.redirect = 1'b0; #1;
        vec++; if ({bus.inst_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 16'h0300}) begin errs++;
            $display("FAIL rh_target_read: got %h want %h", {bus.inst_valid, bus.mem_rd, bus.mem_addr}, {1'b0, 1'b1, 16'h0300}); end
        next(3);
        vec++; if ({bus.inst_valid, bus.inst_opcode, bus.inst_len, bus.inst_pc, bus.inst_next_pc}
                   !== {1'b1, 8'h02, 2'd1, 16'h0300, 16'h0301}) begin errs++;
            $display("FAIL rh_len0_inst: got %h want %h",
                {bus.inst_valid, bus.inst_opcode, bus.inst_len, bus.inst_pc, bus.inst_next_pc},
                {1'b1, 8'h02, 2'd1, 16'h0300, 16'h0301}); end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77; mem[16'h0001] = 8'hAD;
        do_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF; #1;
        vec++; if (bus.mem_rd !== 1'b0) begin errs++;
            $display("FAIL wrap_redirect_rd: got %b want 0", bus.mem_rd); end
        next(1); bus.redirect = 1'b0; #1;
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'hFFFF}) begin errs++;
            $display("FAIL wrap_op_read: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'hFFFF}); end
        next(2);
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0000}) begin errs++;
            $display("FAIL wrap_op1_read: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0000}); end
        next(2);
        vec++; if ({bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_len, bus.inst_pc, bus.inst_next_pc}
                   !== {1'b1, 8'hA9, 8'h77, 2'd2, 16'hFFFF, 16'h0001}) begin errs++;
            $display("FAIL wrap_inst: got %h want %h",
                {bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_len, bus.inst_pc, bus.inst_next_pc},
                {1'b1, 8'hA9, 8'h77, 2'd2, 16'hFFFF, 16'h0001}); end
        bus.inst_ready = 1'b1; #1;
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0001}) begin errs++;
            $display("FAIL wrap_next_read: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0001}); end
        next(1); bus.inst_ready = 1'b0; rst = 1'b1; #1;
        vec++; if (bus.mem_rd !== 1'b0) begin errs++;
            $display("FAIL wrap_rst_rd: got %b want 0", bus.mem_rd); end
        next(1);
        vec++; if ({bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_len, bus.inst_pc}
                   !== {1'b0, 8'h00, 8'h00, 2'd1, 16'h0000}) begin errs++;
            $display("FAIL wrap_rst_state: got %h want %h",
                {bus.inst_valid, bus.inst_opcode, bus.inst_op1, bus.inst_len, bus.inst_pc},
                {1'b0, 8'h00, 8'h00, 2'd1, 16'h0000}); end
        rst = 1'b0; #1;
        vec++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0200}) begin errs++;
            $display("FAIL wrap_rst_restart: got %h want %h", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0200}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_redirect_mid();
        test_redirect_handshake();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the 6502 core, directly upstream of `prime_decoder`. It reads the opcode byte at the current PC from a byte-wide synchronous memory and presents it to the decoder. It then uses the length the decoder returns to fetch zero, one or two operand bytes. The assembled instruction is offered to the execute side with a valid/ready handshake, and a redirect port (branch/jump/interrupt) restarts fetch at a new PC.

## Interface
- `RESET_PC`, 16'h0200: PC loaded on reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_addr` out 16: read address.
- `mem_rd` out 1: read strobe; data returns on `mem_rdata` exactly one cycle later.
- `mem_rdata` in 8: read data.
- `dec_opcode` out 8: latched opcode, fed to the decoder.
- `dec_len` in 2: decoder's instruction length for `dec_opcode` (1..3); 0 is treated as 1.
- `redirect` in 1: load new PC and abandon the current fetch.
- `redirect_pc` in 16: target PC.
- `inst_valid` out 1: instruction available.
- `inst_ready` in 1: consumer accepts.
- `inst_opcode`, `inst_op1`, `inst_op2` out 8 each: opcode and operand bytes. Unused operands are 8'h00.
- `inst_len` out 2: length latched at decode, 1..3.
- `inst_pc` out 16: address of the opcode.
- `inst_next_pc` out 16: `inst_pc + inst_len`, mod 2^16.

## Operation
- Registers:
  - `pc`: next byte address.
  - `state`.
  - Opcode/op1/op2/len/inst_pc registers.
- `dec_opcode` = `inst_opcode` register.
- `mem_addr` = `pc` whenever `mem_rd`=1.
- States:
  - `S_OP`:
    - `mem_rd`=1 at `pc`; `inst_pc` <= `pc`; `pc` <= `pc`+1.
    - Go to `S_OPW`.
  - `S_OPW`:
    - Opcode <= `mem_rdata`; op1, op2 <= 0.
    - Go to `S_OPR`.
  - `S_OPR`:
    - `inst_len` <= `dec_len` (0 becomes 1).
    - If length is 2 or 3: issue read at `pc`, `pc`+1, go to `S_B1W`.
    - Otherwise: go to `S_VALID`.
  - `S_B1W`:
    - op1 <= `mem_rdata`.
    - If `inst_len`=3: issue read at `pc`, `pc`+1, go to `S_B2W`.
    - Otherwise: go to `S_VALID`.
  - `S_B2W`:
    - op2 <= `mem_rdata`.
    - Go to `S_VALID`.
  - `S_VALID`:
    - `inst_valid`=1.
    - If `inst_ready`: issue the next opcode read at `pc` (same actions as `S_OP`), go to `S_OPW`.
    - Otherwise: hold all outputs, `mem_rd`=0, `pc` unchanged.
- `inst_valid` is 1 only in `S_VALID`.
- Redirect (highest priority, any state):
  - `pc` <= `redirect_pc`; state <= `S_OP`.
  - `mem_rd` is forced 0 that cycle.
  - Data returning for an abandoned read is ignored.
- Redirect together with `inst_valid & inst_ready`: the handshake completes (instruction consumed), the redirect wins, and no sequential fetch is issued.
- PC arithmetic is 16-bit and wraps: 16'hFFFF + 1 = 16'h0000.
- `inst_len` is latched; later changes of `dec_len` are ignored until the next `S_OPR`.

## Timing
- Reset values:
  - `state`=`S_OP`, `pc`=`RESET_PC`.
  - `inst_valid`=0.
  - Opcode/op1/op2 = 8'h00, `inst_len`=1, `inst_pc`=0.
  - `mem_rd`=0 while `rst`=1.
- Cycle 0 is the first cycle with `rst`=0:
  - Opcode read issued at cycle 0.
  - `inst_valid` rises at cycle 3 (1 byte), 4 (2 bytes) or 5 (3 bytes).
- Back-to-back with `inst_ready`=1: one instruction every 3/4/5 cycles for 1/2/3-byte instructions. The next opcode read is issued in the accepting `S_VALID` cycle.
- Redirect asserted in cycle n:
  - `inst_valid`=0 from cycle n+1.
  - The read at `redirect_pc` is issued in cycle n+1.
- `rst` asserted mid-instruction: all state is restored to reset values at the next edge; in-flight data is ignored.
- `dec_len` is sampled only in `S_OPR`, one cycle after the opcode is latched. The decoder path may be fully combinational.

## Test plan
- **Single-byte instruction.** Reset with mem[0x0200]=0xEA and `dec_len`=1 -> `mem_addr` 0x0200 at cycle 0; `inst_valid` at cycle 3 with opcode EA, op1=op2=00, `inst_pc` 0200, `inst_next_pc` 0201.
- **Three-byte instruction, back-to-back.** AD 34 12 at 0x0200, `dec_len`=3, `inst_ready`=1 -> valid at cycle 5 with op1=34, op2=12, len 3, `inst_next_pc` 0203; `mem_rd` at 0x0203 in that same cycle; next valid 3 cycles later for a 1-byte follower.
- **Backpressure.** `inst_ready`=0 for 4 cycles in `S_VALID` -> all outputs stable, `mem_rd`=0, `pc` unchanged; accept on cycle 5 -> next read issued that cycle.
- **Redirect mid-fetch.** `redirect`=1 with `redirect_pc`=0x0400 while in `S_B1W` -> op1 not updated as valid, `inst_valid` stays 0, `mem_addr`=0x0400 with `mem_rd`=1 the next cycle.
- **Redirect during handshake.** Redirect in the same cycle as valid&ready -> instruction consumed once, no fetch at the sequential PC, next read at `redirect_pc`.
- **PC wrap.** 2-byte opcode at 0xFFFF -> op1 read from 0x0000, `inst_next_pc`=0x0001. Then assert `rst` mid-fetch -> next read at `RESET_PC`, `inst_valid` 0.
